keypad_scanner: RTL and testbench

- Upstream stage of the 8-digit keypad display path.
- Drives column strobes of a 4x3 phone keypad and samples its row lines.
- Debounces the key, rejects multi-key presses, and produces a one-hot 12-bit key code plus a single-cycle valid strobe.
- Its outputs connect directly to the display block's valid and Scan_data inputs.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, keypad constants and key map for keypad_scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = 12;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;

    typedef enum logic [2:0] {
        IDLE,
        CAND,
        ACCEPT1,
        ACCEPT2,
        HELD
    } scan_state_t;

    // Scan_data bit for the key at (row, col); bottom row holds '*', 0, '#'.
    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        if (row == 2'd3) begin
            case (col)
                2'd0:    idx = 4'(KEY_STAR);
                2'd1:    idx = 4'd0;
                default: idx = 4'(KEY_HASH);
            endcase
        end else begin
            idx = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - parameterized-width 2-flop synchronizer with async active-low reset
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with debounce; KEYPAD_AUTOREPEAT_EN adds held-key auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic        valid,
    output logic [11:0] Scan_data
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      frame_map;
    logic [11:0]      col_bits;
    logic [11:0]      frame_now;
    logic             sample;
    logic             frame_end;
    logic             frame_none;
    logic             frame_one;

    keypad_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_row),
        .q   (row_sync)
    );

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (col_idx == 2'd2);
    assign key_col   = 3'b001 << col_idx;

    always_comb begin
        col_bits = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_sync[r]) col_bits[key_index(2'(r), col_idx)] = 1'b1;
        end
    end

    // The column being sampled on the last dwell cycle is merged in here so
    // the frame decision sees all three columns without an extra cycle.
    assign frame_now  = frame_map | col_bits;
    assign frame_none = (frame_now == 12'd0);
    assign frame_one  = $onehot(frame_now);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            frame_map <= '0;
        end else if (sample) begin
            div_cnt   <= '0;
            col_idx   <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            frame_map <= frame_end ? 12'd0 : frame_now;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    scan_state_t      state_q, state_d;
    logic [11:0]      code_q, code_d;
    logic [DEB_W-1:0] stable_q, stable_d;
    logic [DEB_W-1:0] rel_q, rel_d;
    logic [11:0]      scan_q, scan_d;
    logic             valid_q, valid_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_FRAMES);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            stable_q <= '0;
            rel_q    <= '0;
            scan_q   <= '0;
            valid_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            stable_q <= stable_d;
            rel_q    <= rel_d;
            scan_q   <= scan_d;
            valid_q  <= valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        stable_d = stable_q;
        rel_d    = rel_q;
        scan_d   = scan_q;
        valid_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d    = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_end && frame_one) begin
                    code_d   = frame_now;
                    stable_d = DEB_W'(1);
                    state_d  = (DEBOUNCE_FRAMES == 1) ? ACCEPT1 : CAND;
                end
            end
            CAND: begin
                if (frame_end) begin
                    if (frame_one && frame_now == code_q) begin
                        if (stable_q != DEB_MAX) stable_d = stable_q + 1'b1;
                        if (stable_d == DEB_MAX) state_d = ACCEPT1;
                    end else if (frame_one) begin
                        code_d   = frame_now;
                        stable_d = DEB_W'(1);
                    end else begin
                        stable_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            // Code is published a cycle ahead of valid: downstream latches on valid's rising edge.
            ACCEPT1: begin
                scan_d  = code_q;
                state_d = ACCEPT2;
            end
            ACCEPT2: begin
                valid_d = 1'b1;
                rel_d   = '0;
                state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_d   = '0;
`endif
            end
            HELD: begin
                if (frame_end) begin
                    if (frame_none) begin
                        if (rel_q != DEB_MAX) rel_d = rel_q + 1'b1;
                        if (rel_d == DEB_MAX) begin
                            rel_d    = '0;
                            stable_d = '0;
                            state_d  = IDLE;
                        end
                    end else begin
                        rel_d = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (frame_one && frame_now == code_q) begin
                        if (rep_q != REP_MAX) rep_d = rep_q + 1'b1;
                        if (rep_d == REP_MAX) begin
                            rep_d   = '0;
                            state_d = ACCEPT1;
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid     = valid_q;
    assign Scan_data = scan_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner against a frame-level model
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;
    localparam int FRAME    = 3 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic        valid;
    logic [11:0] Scan_data;
    logic [11:0] pressed = 12'hFFF;

    int tests = 0;
    int fails = 0;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_FRAMES   (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .valid     (valid),
        .Scan_data (Scan_data)
    );

    always #5 clk = ~clk;

    function automatic int key_at(input int r, input int c);
        if (r == 3) return (c == 0) ? 10 : (c == 1) ? 0 : 11;
        return r * 3 + c + 1;
    endfunction

    function automatic logic [3:0] rows_for(input logic [2:0] col, input logic [11:0] p);
        logic [3:0] rr = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (col[c] && p[key_at(r, c)]) rr[r] = 1'b1;
        return rr;
    endfunction

    // Physical keypad: a pressed key shorts its column strobe onto its row line.
    always @* key_row = rows_for(key_col, pressed);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          cyc = 0;
    int          n = 0;
    bit          prev_rst = 1'b0;
    logic [3:0]  rec [int];
    logic [11:0] fmap;
    logic [11:0] frames [$];
    bit          held;
    int          arm_idx, acc_idx, acc_edge;
    logic [11:0] acc_code, exp_scan;
    logic [2:0]  exp_col;
    bit          exp_valid;
    logic        prev_valid = 1'b0;
    logic [11:0] prev_scan = 12'd0;
    int          dut_valid_cnt = 0, model_valid_cnt = 0, first_valid_cyc = -1;

    task automatic model_reset();
        n = 0;
        rec.delete();
        fmap = '0;
        frames.delete();
        held = 1'b0;
        arm_idx = 0;
        acc_idx = 0;
        acc_edge = -1;
        acc_code = '0;
        exp_scan = '0;
    endtask

    task automatic accept(input logic [11:0] code, input int edge_n, input int k);
        held = 1'b1;
        acc_idx = k + 1;
        acc_edge = edge_n;
        acc_code = code;
    endtask

    // Trailing run of frames equal to 'val' back to index 'lo'.
    function automatic int trail(input logic [11:0] val, input int lo);
        int cnt = 0;
        int i = frames.size() - 1;
        while (i >= lo && frames[i] == val) begin
            cnt++;
            i--;
        end
        return cnt;
    endfunction

    task automatic frame_done(input int edge_n);
        logic [11:0] fm;
        int k;
        fm = fmap;
        fmap = '0;
        frames.push_back(fm);
        k = frames.size() - 1;
        if (!held) begin
            if ($onehot(fm) && trail(fm, arm_idx) >= DEB) accept(fm, edge_n, k);
        end else if (trail(12'd0, acc_idx) >= DEB) begin
            held = 1'b0;
            arm_idx = k + 1;
        end else if (AR == 1 && trail(acc_code, acc_idx) >= REP) begin
            accept(acc_code, edge_n, k);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            model_reset();
            check("reset_key_col", 32'(key_col), 32'h1);
            check("reset_valid", 32'(valid), 32'h0);
            check("reset_scan_data", 32'(Scan_data), 32'h0);
            prev_rst = 1'b0;
        end else begin
            if (prev_rst) n++;
            prev_rst = 1'b1;
            rec[n] = key_row;
            if (n > 0 && n % SCAN_DIV == 0) begin
                // Row value reaching the sampler has crossed the 2-flop synchronizer.
                for (int r = 0; r < 4; r++)
                    if (rec[n-3][r]) fmap[key_at(r, ((n - 1) / SCAN_DIV) % 3)] = 1'b1;
                if (n % FRAME == 0) frame_done(n);
            end
            if (acc_edge >= 0 && n == acc_edge + 1) exp_scan = acc_code;
            exp_valid = (acc_edge >= 0 && n == acc_edge + 2);
            if (exp_valid) model_valid_cnt++;
            exp_col = 3'b001 << ((n / SCAN_DIV) % 3);
            check("key_col", 32'(key_col), 32'(exp_col));
            check("valid", 32'(valid), 32'(exp_valid));
            check("scan_data", 32'(Scan_data), 32'(exp_scan));
            if (valid) begin
                check("valid_one_clk_wide", 32'(prev_valid), 32'h0);
                check("scan_stable_before_valid", 32'(Scan_data), 32'(prev_scan));
                dut_valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
        end
        prev_valid = valid;
        prev_scan  = Scan_data;
    end

    task automatic clks(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    int v0, mv0, t0;

    initial begin
        // Reset with all rows high.
        clks(5);
        pressed = 12'h000;
        rst = 1'b1;
        clks(100);
        check("idle_no_valid", 32'(dut_valid_cnt), 32'h0);

        // Key 6 held for 10 frames.
        v0 = dut_valid_cnt; mv0 = model_valid_cnt; first_valid_cyc = -1; t0 = cyc;
        pressed = 12'h040;
        clks(10 * FRAME);
        check("press6_valid_count", 32'(dut_valid_cnt - v0), 32'(1 + AR));
        check("model_press6_count", 32'(model_valid_cnt - mv0), 32'(1 + AR));
        check("press6_scan_data", 32'(Scan_data), 32'h040);
        check("model_press6_scan", 32'(exp_scan), 32'h040);
        check("press6_latency_in_range",
              32'((first_valid_cyc - t0 >= 2 * FRAME) && (first_valid_cyc - t0 <= 4 * FRAME + 6)), 32'h1);
        pressed = 12'h000;
        clks(5 * FRAME);

        // '*' bouncing, then steady.
        v0 = dut_valid_cnt;
        for (int t = 0; t < 7; t++) begin
            pressed = pressed ^ 12'h400;
            clks(5);
        end
        pressed = 12'h400;
        clks(6 * FRAME);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("bounce_valid_count", 32'(dut_valid_cnt - v0), 32'h1);
`endif
        check("bounce_scan_data", 32'(Scan_data), 32'h400);
        pressed = 12'h000;
        clks(5 * FRAME);

        // Keys 1 and 2 together, then 1 alone.
        v0 = dut_valid_cnt;
        pressed = 12'h006;
        clks(10 * FRAME);
        check("multi_no_valid", 32'(dut_valid_cnt - v0), 32'h0);
        check("multi_scan_unchanged", 32'(Scan_data), 32'h400);
        pressed = 12'h002;
        clks(6 * FRAME);
        check("multi_then_single_count", 32'(dut_valid_cnt - v0), 32'h1);
        check("multi_then_single_scan", 32'(Scan_data), 32'h002);
        pressed = 12'h000;
        clks(5 * FRAME);

        // '#' with a one-frame gap, then a three-frame release and re-press.
        v0 = dut_valid_cnt;
        pressed = 12'h800; clks(5 * FRAME);
        pressed = 12'h000; clks(FRAME);
        pressed = 12'h800; clks(4 * FRAME);
        check("short_gap_single_valid", 32'(dut_valid_cnt - v0), 32'h1);
        check("hash_scan_data", 32'(Scan_data), 32'h800);
        pressed = 12'h000; clks(3 * FRAME);
        pressed = 12'h800; clks(6 * FRAME);
        check("repress_second_valid", 32'(dut_valid_cnt - v0), 32'h2);
        pressed = 12'h000;
        clks(5 * FRAME);

        // Key 0 with a reset pulse during debounce.
        pressed = 12'h001;
        clks(2 * FRAME);
        rst = 1'b0;
        clks(2);
        check("reset_mid_cand_scan_cleared", 32'(Scan_data), 32'h0);
        rst = 1'b1;
        v0 = dut_valid_cnt; first_valid_cyc = -1; t0 = cyc;
        clks(6 * FRAME);
        check("after_reset_valid_count", 32'(dut_valid_cnt - v0), 32'h1);
        check("after_reset_full_debounce", 32'(first_valid_cyc - t0 >= DEB * FRAME), 32'h1);
        check("after_reset_scan_data", 32'(Scan_data), 32'h001);
        v0 = dut_valid_cnt;
        clks(20 * FRAME);
        check("held_repeat_count", 32'(dut_valid_cnt - v0), 32'(4 * AR));
        pressed = 12'h000;
        clks(5 * FRAME);

        // Random key patterns with one random reset.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0:       pressed = 12'h000;
                3:       pressed = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
                default: pressed = 12'h001 << $urandom_range(0, 11);
            endcase
            clks($urandom_range(6, 80));
            if (t == 15) begin
                rst = 1'b0;
                clks($urandom_range(1, 3));
                rst = 1'b1;
            end
        end
        pressed = 12'h000;
        clks(5 * FRAME);
        check("model_dut_valid_totals_agree", 32'(dut_valid_cnt >= model_valid_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
